// File: rtl/ysyx_23060184_mdu_pkg.sv
// Shared RV32M op encodings (funct3) and MDU control types.
package ysyx_23060184_mdu_pkg;

    localparam int MDU_OP_LENGTH = 3;

    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MUL    = 3'd0;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULH   = 3'd1;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIV    = 3'd4;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_REM    = 3'd6;
    localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_div(input logic [MDU_OP_LENGTH-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [MDU_OP_LENGTH-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ysyx_23060184_mdu_div.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
module ysyx_23060184_mdu_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   shifted;
    logic [W:0]   diff;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        // Partial remainder with the next dividend bit shifted in from quo_q.
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ysyx_23060184_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and FSM here,
// restoring divider in a sub-module; div-by-zero and overflow finish at accept.
module ysyx_23060184_mdu
    import ysyx_23060184_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [MDU_OP_LENGTH-1:0] MDUOp,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int W = DATA_WIDTH;

    mdu_state_e               state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [MDU_OP_LENGTH-1:0] op_q, op_d;
    logic                     neg_q, neg_d;
    logic                     bneg_q, bneg_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic [2*W-1:0]           mcand_q, mcand_d;
    logic [W-1:0]             mplier_q, mplier_d;
    logic [W-1:0]             result_q, result_d;

    logic                     a_sgn, b_sgn, sa, sb;
    logic [W-1:0]             a_mag, b_mag, quo, rem;
    logic                     bypass;
    logic [W-1:0]             bypass_res;
    logic [2*W-1:0]           addend;
    logic                     div_load, div_step;

    // Operand decode on the live inputs; only consumed on the accepting edge.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (MDUOp)
            MDU_OP_MULH:             begin a_sgn = 1'b1; b_sgn = 1'b1; end
            MDU_OP_MULHSU:           a_sgn = 1'b1;
            MDU_OP_DIV, MDU_OP_REM:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:                 ;
        endcase
        sa    = SrcA[W-1] & a_sgn;
        sb    = SrcB[W-1] & b_sgn;
        a_mag = sa ? -SrcA : SrcA;
        b_mag = sb ? -SrcB : SrcB;

        bypass     = 1'b0;
        bypass_res = '0;
        if (is_div(MDUOp)) begin
            if (SrcB == '0) begin
                bypass     = 1'b1;
                bypass_res = is_rem(MDUOp) ? SrcA : '1;
            end else if (a_sgn && SrcA == {1'b1, {(W-1){1'b0}}} && SrcB == '1) begin
                bypass     = 1'b1;
                bypass_res = is_rem(MDUOp) ? '0 : SrcA;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        bneg_d   = bneg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        div_load = 1'b0;
        div_step = 1'b0;
        addend   = mplier_q[0] ? mcand_q : '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d  = MDUOp;
                    cnt_d = '0;
                    if (bypass) begin
                        result_d = bypass_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                        div_load = 1'b1;
                        acc_d    = '0;
                        mcand_d  = {{W{sa}}, SrcA};
                        mplier_d = SrcB;
                        bneg_d   = b_sgn;
                        neg_d    = (MDUOp == MDU_OP_DIV) ? (sa ^ sb) :
                                   (MDUOp == MDU_OP_REM) ? sa : 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < 6'(W)) begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 6'd1;
                    // A signed multiplier's MSB carries weight -2^(W-1).
                    acc_d    = (cnt_q == 6'(W-1) && bneg_q) ? acc_q - addend : acc_q + addend;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    case (op_q)
                        MDU_OP_MUL:                              result_d = acc_q[W-1:0];
                        MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: result_d = acc_q[2*W-1:W];
                        MDU_OP_DIV, MDU_OP_DIVU:                 result_d = neg_q ? -quo : quo;
                        default:                                 result_d = neg_q ? -rem : rem;
                    endcase
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d  = ST_IDLE;
                    result_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            bneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            bneg_q   <= bneg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    ysyx_23060184_mdu_div #(
        .W(W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Result    = out_valid ? result_q : '0;

endmodule

// File: tb/tb_ysyx_23060184_mdu.sv
// Randomized and directed checks of the MDU against an arithmetic reference model.
module tb_ysyx_23060184_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  MDUOp = '0;
    logic        in_ready, out_valid;
    logic [31:0] Result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_res = '0;
    bit          exp_live = 1'b0;

    ysyx_23060184_mdu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .MDUOp(MDUOp), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // RV32M semantics straight from 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Per-cycle output check: Result matches the model while valid, else zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (!exp_live) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got out_valid=1 want 0 (Result=%h)", Result);
                end else begin
                    chk("cyc_result", Result, exp_res);
                end
            end else begin
                chk("cyc_zero", Result, 32'h0);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int          lat;
        int          explat;
        bit          busy_bad;
        bit          hold_bad;
        logic [31:0] expv;
        expv     = model(op, a, b);
        explat   = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 0 : 33;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        @(negedge clk);
        exp_res  = expv;
        exp_live = 1'b1;
        SrcA     = a;
        SrcB     = b;
        MDUOp    = op;
        in_valid = 1'b1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        SrcA     = $urandom;
        SrcB     = $urandom;
        MDUOp    = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("edges_after_accept", 32'(lat), 32'(explat));
        chk("busy_ready", 32'(busy_bad), 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready) hold_bad = 1'b1;
        end
        if (hold > 0) chk("hold_stable", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_live  = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        $display("op=%0d a=%h b=%h exp=%h edges=%0d hold=%0d", op, a, b, expv, lat, hold);
    endtask

    task automatic abort_mid(input bit use_rst);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        exp_live = 1'b0;
        SrcA     = 32'h12345678;
        SrcB     = 32'h9ABCDEF1;
        MDUOp    = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        chk(use_rst ? "rst_valid" : "flush_valid", 32'(out_valid), 32'd0);
        chk(use_rst ? "rst_ready" : "flush_ready", 32'(in_ready), 32'd1);
        chk(use_rst ? "rst_result" : "flush_result", Result, 32'h0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk(use_rst ? "rst_no_valid" : "flush_no_valid", 32'(seen), 32'd0);
        $display("abort mid-busy via %s", use_rst ? "rst" : "flush");
        run_op(3'd0, 32'd3, 32'd4, 0);
    endtask

    localparam int NPIN = 12;
    logic [2:0]  pin_op  [NPIN] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] pin_a   [NPIN] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                    32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] pin_b   [NPIN] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                    32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] pin_exp [NPIN] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                    32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_result", Result, 32'h0);

        for (int i = 0; i < NPIN; i++) begin
            chk("model_pin", model(pin_op[i], pin_a[i], pin_b[i]), pin_exp[i]);
            run_op(pin_op[i], pin_a[i], pin_b[i], (i == 0) ? 5 : 0);
        end

        // Flush while idle must block an otherwise instant bypass accept.
        @(negedge clk);
        exp_live = 1'b0;
        MDUOp    = 3'd5;
        SrcA     = 32'd9;
        SrcB     = 32'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_ready", 32'(in_ready), 32'd1);
        chk("idle_flush_valid", 32'(out_valid), 32'd0);
        $display("flush while idle with in_valid");

        abort_mid(1'b0);
        abort_mid(1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rop;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 15));
            run_op(rop, ra, rb, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
